// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its scoreboard.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;

    // Architectural register indices with special meaning.
    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback.
// Latency: busy bits update on the next rising edge; Stall_o is combinational.
// Backpressure: raises Stall_o for the issuer to hold; never gates Issue_i itself.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] A1_i,
    input  logic [ADDR_W-1:0] A2_i,
    input  logic [ADDR_W-1:0] A3_i,
    input  logic              WE3_i,
    input  logic              Issue_i,
    input  logic [ADDR_W-1:0] IssueRd_i,
    output logic              Stall_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             stall_rs1;
    logic             stall_rs2;

    // Clear on writeback first, then set on issue so a same-index issue wins.
    always_comb begin
        busy_nxt = busy;
        if (WE3_i) begin
            busy_nxt[A3_i] = 1'b0;
        end
        if (Issue_i && (IssueRd_i != ZERO_IDX)) begin
            busy_nxt[IssueRd_i] = 1'b1;
        end
    end

    // Busy-bit state; reset drops every outstanding producer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // A source stalls only if busy and not being resolved by this cycle's writeback.
    always_comb begin
        stall_rs1 = (A1_i != ZERO_IDX) && busy[A1_i] && !(WE3_i && (A3_i == A1_i));
        stall_rs2 = (A2_i != ZERO_IDX) && busy[A2_i] && !(WE3_i && (A3_i == A2_i));
        Stall_o   = stall_rs1 || stall_rs2;
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through bypass and busy scoreboard.
// Latency: reads and Stall_o combinational; writes land on the next rising edge.
// Backpressure: Stall_o asks the issue stage to hold; issue is not gated here.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] A1_i,
    input  logic [ADDR_W-1:0] A2_i,
    output logic [DATA_W-1:0] RD1_o,
    output logic [DATA_W-1:0] RD2_o,
    input  logic [ADDR_W-1:0] A3_i,
    input  logic [DATA_W-1:0] WD3_i,
    input  logic              WE3_i,
    input  logic              Issue_i,
    input  logic [ADDR_W-1:0] IssueRd_i,
    output logic              Stall_o,
    output logic [DATA_W-1:0] a0_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] A0_IDX   = ADDR_W'(REG_A0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

    // x0 is never written; the bypass is also suppressed while reset is held
    // so the read ports show zero during reset.
    assign wr_en = WE3_i && (A3_i != ZERO_IDX) && rst_ni;

    // Data array; x0 stays at zero because wr_en excludes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[A3_i] <= WD3_i;
        end
    end

    // Read ports with same-cycle write-through bypass.
    always_comb begin
        RD1_o = regs[A1_i];
        RD2_o = regs[A2_i];
        if (wr_en && (A3_i == A1_i)) begin
            RD1_o = WD3_i;
        end
        if (wr_en && (A3_i == A2_i)) begin
            RD2_o = WD3_i;
        end
        if (A1_i == ZERO_IDX) begin
            RD1_o = '0;
        end
        if (A2_i == ZERO_IDX) begin
            RD2_o = '0;
        end
    end

    // a0 debug view comes straight from the array, no bypass.
    assign a0_o = regs[A0_IDX];

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .A1_i      (A1_i),
        .A2_i      (A2_i),
        .A3_i      (A3_i),
        .WE3_i     (WE3_i),
        .Issue_i   (Issue_i),
        .IssueRd_i (IssueRd_i),
        .Stall_o   (Stall_o)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, x0, scoreboard set/clear, mid-cycle reset.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: n/a.
module tb_regfile_sb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  A1_i, A2_i, A3_i, IssueRd_i;
    logic [31:0] WD3_i;
    logic        WE3_i, Issue_i;
    logic [31:0] RD1_o, RD2_o, a0_o;
    logic        Stall_o;

    int n_pass  = 0;
    int n_total = 0;

    regfile_sb dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .A1_i      (A1_i),
        .A2_i      (A2_i),
        .RD1_o     (RD1_o),
        .RD2_o     (RD2_o),
        .A3_i      (A3_i),
        .WD3_i     (WD3_i),
        .WE3_i     (WE3_i),
        .Issue_i   (Issue_i),
        .IssueRd_i (IssueRd_i),
        .Stall_o   (Stall_o),
        .a0_o      (a0_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Step past the next rising edge, then settle before driving.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        WE3_i = 1'b0; A3_i = '0; WD3_i = '0;
        Issue_i = 1'b0; IssueRd_i = '0;
    endtask

    initial begin
        rst_ni = 1'b0;
        A1_i = '0; A2_i = '0;
        idle();
        #2;

        // Reset state: every index reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            A1_i = 5'(i);
            A2_i = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1_x%0d", i), RD1_o, 32'h0);
            chk($sformatf("rst_rd2_x%0d", 31 - i), RD2_o, 32'h0);
        end
        chk("rst_stall", {31'b0, Stall_o}, 32'h0);
        chk("rst_a0", a0_o, 32'h0);
        // A writeback presented during reset must not bypass.
        WE3_i = 1'b1; A3_i = 5'd5; WD3_i = 32'hFFFF_FFFF; A1_i = 5'd5;
        #1;
        chk("rst_no_bypass", RD1_o, 32'h0);

        // Release mid-cycle with x5 write already presented: lands on first edge.
        @(negedge clk_i);
        rst_ni = 1'b1;
        WD3_i = 32'hDEAD_BEEF;
        #1;
        chk("bypass_x5", RD1_o, 32'hDEAD_BEEF);
        tick();
        idle();
        A2_i = 5'd5;
        #1;
        chk("array_x5_rd1", RD1_o, 32'hDEAD_BEEF);
        chk("array_x5_rd2", RD2_o, 32'hDEAD_BEEF);

        // x0 ignores writes and is never busy.
        WE3_i = 1'b1; A3_i = 5'd0; WD3_i = 32'h1234_5678; A1_i = 5'd0;
        #1;
        chk("x0_bypass", RD1_o, 32'h0);
        tick();
        idle();
        Issue_i = 1'b1; IssueRd_i = 5'd0;
        #1;
        chk("x0_after_wr", RD1_o, 32'h0);
        tick();
        idle();
        A1_i = 5'd0; A2_i = 5'd0;
        #1;
        chk("x0_no_stall", {31'b0, Stall_o}, 32'h0);

        // Issue rd=7, then see stall, then resolve via same-cycle writeback.
        Issue_i = 1'b1; IssueRd_i = 5'd7;
        tick();
        idle();
        A2_i = 5'd7;
        #1;
        chk("busy7_stall", {31'b0, Stall_o}, 32'h1);
        WE3_i = 1'b1; A3_i = 5'd7; WD3_i = 32'h0000_0077;
        #1;
        chk("wb7_unstall", {31'b0, Stall_o}, 32'h0);
        chk("wb7_bypass", RD2_o, 32'h0000_0077);
        tick();
        idle();
        #1;
        chk("busy7_clear", {31'b0, Stall_o}, 32'h0);
        chk("x7_value", RD2_o, 32'h0000_0077);

        // Same-index issue and writeback: new producer keeps the bit set.
        A2_i = 5'd0;
        Issue_i = 1'b1; IssueRd_i = 5'd3;
        WE3_i = 1'b1; A3_i = 5'd3; WD3_i = 32'h0000_0033;
        tick();
        idle();
        A1_i = 5'd3;
        #1;
        chk("busy3_kept", {31'b0, Stall_o}, 32'h1);
        chk("x3_value", RD1_o, 32'h0000_0033);

        // Different-index issue and writeback both take effect.
        Issue_i = 1'b1; IssueRd_i = 5'd4;
        WE3_i = 1'b1; A3_i = 5'd3; WD3_i = 32'h0000_0034;
        tick();
        idle();
        A1_i = 5'd3;
        #1;
        chk("busy3_cleared", {31'b0, Stall_o}, 32'h0);
        chk("x3_updated", RD1_o, 32'h0000_0034);
        A1_i = 5'd0; A2_i = 5'd4;
        #1;
        chk("busy4_set_rs2", {31'b0, Stall_o}, 32'h1);
        A1_i = 5'd4; A2_i = 5'd0;
        #1;
        chk("busy4_set_rs1", {31'b0, Stall_o}, 32'h1);

        // Writeback to a non-busy index leaves it clear.
        WE3_i = 1'b1; A3_i = 5'd6; WD3_i = 32'hCAFE_0006;
        A1_i = 5'd0;
        tick();
        idle();
        A1_i = 5'd6;
        #1;
        chk("x6_value", RD1_o, 32'hCAFE_0006);
        chk("x6_not_busy", {31'b0, Stall_o}, 32'h0);

        // a0 view has no bypass, then follows x10 after the edge.
        WE3_i = 1'b1; A3_i = 5'd10; WD3_i = 32'h0000_0042;
        #1;
        chk("a0_no_bypass", a0_o, 32'h0);
        tick();
        idle();
        #1;
        chk("a0_written", a0_o, 32'h0000_0042);

        // Leave rd=12 outstanding, then assert reset mid-cycle with a writeback pending.
        Issue_i = 1'b1; IssueRd_i = 5'd12;
        tick();
        idle();
        A1_i = 5'd12; A2_i = 5'd11;
        #1;
        chk("busy12_stall", {31'b0, Stall_o}, 32'h1);
        WE3_i = 1'b1; A3_i = 5'd11; WD3_i = 32'h0000_0099;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_a0", a0_o, 32'h0);
        chk("mid_rst_stall", {31'b0, Stall_o}, 32'h0);
        chk("mid_rst_rd2", RD2_o, 32'h0);
        tick();
        // Release mid-cycle with a write to x10 pending: first edge takes it.
        @(negedge clk_i);
        WE3_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        chk("post_rst_stall", {31'b0, Stall_o}, 32'h0);
        chk("post_rst_x11", RD2_o, 32'h0);
        chk("post_rst_x6", {27'b0, A1_i} == 32'd12 ? RD1_o : 32'hBAD0_BAD0, 32'h0);
        WE3_i = 1'b1; A3_i = 5'd10; WD3_i = 32'h0000_0055;
        tick();
        idle();
        #1;
        chk("first_wr_a0", a0_o, 32'h0000_0055);
        chk("post_rst_x11_held", RD2_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish within 50000ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5: register-index width; depth is 2**ADDR_W.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset; it SHALL expose exactly these ports:
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 A1_i  input  ADDR_W  read-port-1 index (rs1).
REQ-007 A2_i  input  ADDR_W  read-port-2 index (rs2).
REQ-008 RD1_o  output  DATA_W  read-port-1 data.
REQ-009 RD2_o  output  DATA_W  read-port-2 data.
REQ-010 A3_i  input  ADDR_W  writeback index (rd).
REQ-011 WD3_i  input  DATA_W  writeback data from the result mux.
REQ-012 WE3_i  input  1  writeback enable.
REQ-013 Issue_i  input  1  an instruction with a register destination issues this cycle.
REQ-014 IssueRd_i  input  ADDR_W  destination index of the issuing instruction.
REQ-015 Stall_o  output  1  rs1 or rs2 has an outstanding producer; hold issue.
REQ-016 a0_o  output  DATA_W  continuous view of register x10 (a0).

Function
REQ-017 Reads SHALL be combinational: RD1_o = reg[A1_i], RD2_o = reg[A2_i].
REQ-018 Index 0 SHALL read as 0 on both ports, ignore writes, and never be marked busy.
REQ-019 When WE3_i=1 and A3_i!=0, reg[A3_i] SHALL take WD3_i at the next rising edge.
REQ-020 Write-through bypass: when WE3_i=1, A3_i!=0 and A3_i equals A1_i (or A2_i), RD1_o (RD2_o) SHALL equal WD3_i in the same cycle.
REQ-021 a0_o SHALL reflect reg[10] after the write edge; no bypass applies to a0_o.
REQ-022 Scoreboard: one busy bit per index; Issue_i=1 with IssueRd_i!=0 SHALL set busy[IssueRd_i] at the next edge.
REQ-023 WE3_i=1 SHALL clear busy[A3_i] at the next edge.
REQ-024 Simultaneous issue and writeback to the same index SHALL leave the bit set (the new producer wins).
REQ-025 Simultaneous issue and writeback to different indices SHALL both take effect.
REQ-026 Stall_o SHALL be 1 iff, for rs1 or rs2, the index is non-zero, its busy bit is set, and it is not being written back this cycle (WE3_i=1, A3_i equal to that index).
REQ-027 Stall_o SHALL be combinational with zero latency; the block SHALL NOT gate Issue_i with Stall_o.
REQ-028 Writeback to a non-busy index SHALL update data and leave busy clear.

Reset
REQ-029 While rst_ni=0, all registers SHALL be 0 and all busy bits clear, so RD1_o=RD2_o=a0_o=0 and Stall_o=0.
REQ-030 Reset asserted mid-operation SHALL discard pending busy bits and any same-cycle writeback.
REQ-031 The first write after reset deassertion SHALL take effect on the first rising edge with rst_ni=1.

Structure
REQ-032 Shared package regfile_pkg SHALL hold DATA_W, ADDR_W defaults, REG_ZERO=0 and REG_A0=10.
REQ-033 The scoreboard SHALL be the single sub-module reg_scoreboard (busy bits, set/clear logic, Stall_o); the data array stays in regfile_sb.

Verification
REQ-034 Reset, then read all 32 indices -> all 0, Stall_o=0, a0_o=0.
REQ-035 Write x5=0xDEADBEEF with A1_i=5 in the same cycle -> RD1_o=0xDEADBEEF before the edge; after the edge it still reads 0xDEADBEEF via the array.
REQ-036 Write x0=0x12345678 -> RD1_o for index 0 stays 0; issue rd=0 -> Stall_o stays 0.
REQ-037 Issue rd=7, next cycle A2_i=7 -> Stall_o=1; same cycle WE3_i=1, A3_i=7 -> Stall_o=0; next cycle busy[7] is clear.
REQ-038 Issue rd=3 and writeback A3_i=3 in the same cycle -> busy[3] remains set, Stall_o=1 when A1_i=3 next cycle.
REQ-039 Write x10=0x00000042, then pulse rst_ni low mid-cycle -> a0_o=0 immediately and all busy bits clear.
